// File: rtl/decoder_sweep_n.sv
// Registered N-to-2^N one-hot decoder with a direct mode and a self-timed sweep mode.
// Define DECODER_ACTIVE_LOW_EN to drive y as active-low strobes (inactive value all ones).
module decoder_sweep_n #(
    parameter int N    = 3,
    parameter int HOLD = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        a,
    output logic [(1<<N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                y_valid,
    output logic                sweep_done
);
    localparam int W = 1 << N;
    localparam logic [7:0]   HOLD_LAST = 8'(HOLD - 1);
    localparam logic [N-1:0] STEP_LAST = {N{1'b1}};

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N-1:0]   step_q, step_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           y_valid_q, y_valid_d;
    logic           sweep_done_q, sweep_done_d;
    logic           accept;

    assign in_ready = en & ~rst & (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        idx_d        = idx_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        y_valid_d    = y_valid_q;
        sweep_done_d = sweep_done_q;
        // With en low nothing moves, so pending pulses survive until en returns.
        if (en) begin
            y_valid_d    = 1'b0;
            sweep_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        y_d   = W'(1) << a;
                        idx_d = a;
                        if (mode) begin
                            state_d = SWEEP;
                            cnt_d   = 8'd0;
                            step_d  = '0;
                        end else begin
                            y_valid_d = 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = 8'd0;
                        if (step_q == STEP_LAST) begin
                            state_d      = DONE;
                            y_d          = '0;
                            sweep_done_d = 1'b1;
                        end else begin
                            idx_d  = idx_q + N'(1);
                            step_d = step_q + N'(1);
                            y_d    = W'(1) << (idx_q + N'(1));
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            y_q          <= '0;
            idx_q        <= '0;
            step_q       <= '0;
            cnt_q        <= 8'd0;
            y_valid_q    <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            idx_q        <= idx_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            y_valid_q    <= y_valid_d;
            sweep_done_q <= sweep_done_d;
        end
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign y = ~(y_q & {W{en}});
`else
    assign y = y_q & {W{en}};
`endif
    assign idx        = idx_q;
    assign y_valid    = y_valid_q & en;
    assign sweep_done = sweep_done_q & en;

endmodule

// File: tb/tb_decoder_sweep_n.sv
// Randomized bench for decoder_sweep_n; reference model expands each sweep into a script of per-cycle outputs.
module tb_decoder_sweep_n;
    localparam int N    = 3;
    localparam int HOLD = 2;
    localparam int W    = 1 << N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1, mode = 1'b0, in_valid = 1'b0;
    logic [N-1:0] a = '0;
    logic         in_ready, y_valid, sweep_done;
    logic [W-1:0] y;
    logic [N-1:0] idx;

    int errors = 0;
    int checks = 0;

    decoder_sweep_n #(.N(N), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .y(y), .idx(idx), .y_valid(y_valid),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y1h;
        logic [N-1:0] idx;
        logic         yv;
        logic         sd;
    } ent_t;

    ent_t cur;
    ent_t script[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_y(input logic [W-1:0] y1h, input logic e);
`ifdef DECODER_ACTIVE_LOW_EN
        return e ? ~y1h : {W{1'b1}};
`else
        return e ? y1h : '0;
`endif
    endfunction

    task automatic model_reset();
        cur = '{y1h: '0, idx: '0, yv: 1'b0, sd: 1'b0};
        script.delete();
    endtask

    // Busy means a sweep is still scripted or the done cycle is showing.
    function automatic logic model_busy();
        return (script.size() != 0) || cur.sd;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic v,
                              input logic m, input logic [N-1:0] aa);
        ent_t t;
        if (r) begin
            model_reset();
        end else if (e) begin
            if (script.size() != 0) begin
                cur = script.pop_front();
            end else if (cur.sd) begin
                cur.y1h = '0;
                cur.sd  = 1'b0;
            end else if (v) begin
                cur.y1h = W'(1) << aa;
                cur.idx = aa;
                cur.yv  = ~m;
                cur.sd  = 1'b0;
                if (m) begin
                    for (int k = 1; k < W * HOLD; k++) begin
                        t.idx = N'((int'(aa) + k / HOLD) % W);
                        t.y1h = W'(1) << t.idx;
                        t.yv  = 1'b0;
                        t.sd  = 1'b0;
                        script.push_back(t);
                    end
                    t.idx = N'((int'(aa) + W - 1) % W);
                    t.y1h = '0;
                    t.yv  = 1'b0;
                    t.sd  = 1'b1;
                    script.push_back(t);
                end
            end else begin
                cur.yv = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("y", y, exp_y(cur.y1h, en));
        if (!cur.sd) chk("idx", idx, cur.idx);
        chk("y_valid", y_valid, cur.yv & en);
        chk("sweep_done", sweep_done, cur.sd & en);
        chk("in_ready", in_ready, en & ~rst & ~model_busy());
    endtask

    task automatic cycle(input logic r, input logic e, input logic v,
                         input logic m, input logic [N-1:0] aa);
        @(negedge clk);
        rst = r; en = e; in_valid = v; mode = m; a = aa;
        if (r) model_reset();
        #1 check_outputs();
        @(posedge clk);
        model_step(r, e, v, m, aa);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_y", y, exp_y('0, en));
        chk("async_rst_idx", idx, '0);
        chk("async_rst_done", sweep_done, 1'b0);
        @(posedge clk);
        model_step(1'b1, en, in_valid, mode, a);
    endtask

    initial begin
        model_reset();
        cycle(1, 1, 0, 0, '0);
        cycle(1, 1, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);

        // Direct decode of every address back to back.
        for (int i = 0; i < W; i++) cycle(0, 1, 1, 0, N'(i));
        cycle(0, 1, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);

        // Sweep from 6 with a direct request to 3 held throughout.
        cycle(0, 1, 1, 1, N'(6));
        for (int i = 0; i < W * HOLD + 3; i++) cycle(0, 1, 1, 0, N'(3));
        cycle(0, 1, 0, 0, '0);

        // Freeze mid-sweep at idx 2.
        cycle(0, 1, 1, 1, N'(0));
        for (int i = 0; i < 40 && !(cur.idx == N'(2) && script.size() != 0); i++)
            cycle(0, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, N'(5));
        for (int i = 0; i < W * HOLD + 4; i++) cycle(0, 1, 0, 0, '0);

        // Asynchronous reset mid-sweep at idx 4.
        cycle(0, 1, 1, 1, N'(1));
        for (int i = 0; i < 40 && cur.idx != N'(4); i++) cycle(0, 1, 0, 0, '0);
        mid_reset();
        cycle(1, 1, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);

        // Random traffic including enable drops and occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                  $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                  N'($urandom_range(0, W - 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decoder_sweep_n.md
Name: decoder_sweep_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake.
- Two modes:
  - Direct: registered decode of a single address.
  - Sweep: walks the one-hot strobe through all 2^N outputs, starting from a given address.
- Drives row/digit strobes and chip-selects in display-scan and bus-select paths; supersedes the fixed 3-to-8 combinational decoder.

Parameters:
- N, 3, address width; output width is 2**N (legal range 1..6).
- HOLD, 1, cycles each strobe is held during a sweep (legal range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  global enable; 0 freezes all state and forces y to the inactive value.
- mode  input  1  sampled on accept; 0 selects direct, 1 selects sweep.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  N  decode address, or sweep start index.
- y  output  2**N  registered one-hot strobe.
- idx  output  N  index currently asserted on y.
- y_valid  output  1  1-cycle pulse when y is updated by a direct accept.
- sweep_done  output  1  1-cycle pulse after the last sweep step.

Behaviour:
- Reset, asynchronous and active-high:
  - y = 0, idx = 0, y_valid = 0, sweep_done = 0.
  - State goes to IDLE; hold counter cleared.
  - in_ready = 1 once rst deasserts.
- Accept condition: in_valid & in_ready & en.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - in_ready = en.
  - Accept with mode=0: next cycle y = 1<<a, idx = a, y_valid = 1 for one cycle. Stay in IDLE. y holds until the next accept. Back-to-back accepts every cycle are legal.
  - Accept with mode=1: next cycle y = 1<<a, idx = a, hold counter = 0. Go to SWEEP. y_valid stays 0.
- SWEEP:
  - in_ready = 0.
  - Each en cycle the hold counter increments.
  - When hold counter = HOLD-1: counter clears, idx advances by +1 modulo 2^N (wraps 2^N-1 to 0), y = 1<<idx.
  - After exactly 2^N strobes have each been shown for HOLD cycles, go to DONE. Total sweep length is 2^N*HOLD cycles from the first strobe.
- DONE:
  - y = 0, sweep_done = 1 for one cycle. Next cycle returns to IDLE.
  - in_ready stays 0 in DONE.
- en = 0:
  - y is forced to the inactive value combinationally from the register, i.e. ANDed with en.
  - FSM, idx and hold counter freeze; no accept occurs.
  - Pulses (y_valid, sweep_done) are deferred until en returns.
- Reset mid-sweep: immediate return to reset values; no sweep_done pulse.
- in_valid asserted while in_ready = 0: ignored. The request is not queued; the source must hold it.
- Width rule: idx arithmetic is N bits, wrapping naturally.
- Invariant: y is always either zero or exactly one-hot.

Optional Feature:
- Macro: DECODER_ACTIVE_LOW_EN.
- Defined:
  - y is driven inverted (active-low strobes).
  - Reset value and inactive value of y are all ones.
  - en = 0 forces all ones.
  - DONE drives all ones.
- Undefined: active-high as described above.
- idx, y_valid and sweep_done are unaffected in both cases.

Test Plan:
- Direct decode: N=3; reset, then accept mode=0 with a = 0..7 on consecutive cycles -> one cycle after each accept, y = 00000001, 00000010, … 10000000; y_valid high on each of those cycles; in_ready stays 1.
- Sweep with wrap: N=3, HOLD=2; accept mode=1, a=6 -> idx sequence 6,6,7,7,0,0,1,1,…,5,5 (16 cycles); then y=0 with sweep_done=1 for 1 cycle; in_ready=0 throughout the sweep, and 1 again the cycle after DONE.
- Request during sweep: in_valid=1, a=3 held during a sweep -> ignored while busy; accepted on the first IDLE cycle after DONE -> y=00001000.
- Enable freeze: drop en for 5 cycles at idx=2 mid-sweep -> y=0 for those 5 cycles; idx stays 2; sweep resumes on the same strobe and completes 5 cycles later than an unfrozen sweep.
- Reset mid-sweep: assert rst asynchronously (between clock edges) at idx=4 -> y=0 and idx=0 immediately; no sweep_done pulse; in_ready=1 after release.
- Active-low build: define DECODER_ACTIVE_LOW_EN, N=2; direct accept a=1 -> y=1101; after reset y=1111.
